sig_bucket_sched: RTL

//  Scheduler and arbiter between the minhash controller and one single-port signature bucket memory.
//  - Write beats carry S signature values plus one window index and genome id; each signature is written to its own bucket slot.
//  - Lookups scan one bucket and stream every entry whose stored key matches.
//  - Read and write requesters share the memory; the block arbitrates between them.

---
 rtl/sig_bucket_sched.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sig_bucket_sched.sv
// Scheduler/arbiter between the minhash controller and a single-port signature bucket memory.
// Optional drop counter output enabled with `define LSH_DROP_CNT_EN.
module sig_bucket_sched #(
  parameter int S      = 4,
  parameter int KEY_W  = 32,
  parameter int WI_W   = 32,
  parameter int GID_W  = 8,
  parameter int BKT_W  = 6,
  parameter int SLOT_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [S*KEY_W-1:0]             wr_sig,
  input  logic [WI_W-1:0]                wr_wi,
  input  logic [GID_W-1:0]               wr_gid,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [KEY_W-1:0]               rd_key,
  output logic                           m_valid,
  output logic [WI_W-1:0]                m_wi,
  output logic [GID_W-1:0]               m_gid,
  output logic                           rd_done,
  output logic                           rd_found,
  input  logic                           clr,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [BKT_W+SLOT_W-1:0]        mem_addr,
  output logic [KEY_W+WI_W+GID_W-1:0]    mem_wdata,
  input  logic [KEY_W+WI_W+GID_W-1:0]    mem_rdata
`ifdef LSH_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_cnt
`endif
);

  localparam int NB = 1 << BKT_W;
  localparam int DW = KEY_W + WI_W + GID_W;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [SLOT_W:0] OCC_MAX = (SLOT_W + 1)'(1 << SLOT_W);
  localparam logic [SLOT_W:0] OCC_ONE = (SLOT_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t              r_state, w_next;
  logic [SLOT_W:0]     r_occ [NB];
  logic                r_last_rd;
  logic [IW-1:0]       r_idx;
  logic [S*KEY_W-1:0]  r_sig;
  logic [WI_W-1:0]     r_wi;
  logic [GID_W-1:0]    r_gid;
  logic [KEY_W-1:0]    r_key;
  logic [SLOT_W:0]     r_k;
  logic                r_pend;
  logic                r_found;

  logic [KEY_W-1:0]    w_wsig;
  logic [BKT_W-1:0]    w_wbkt;
  logic [BKT_W-1:0]    w_rbkt;
  logic [BKT_W-1:0]    w_ibkt;
  logic                w_wfull;
  logic                w_match;

  assign w_wsig  = r_sig[r_idx*KEY_W +: KEY_W];
  assign w_wbkt  = w_wsig[BKT_W-1:0];
  assign w_rbkt  = r_key[BKT_W-1:0];
  assign w_ibkt  = rd_key[BKT_W-1:0];
  assign w_wfull = (r_occ[w_wbkt] == OCC_MAX);

  // Word read last cycle is compared now; r_pend marks that a read was issued.
  assign w_match  = r_pend && (mem_rdata[DW-1 -: KEY_W] == r_key);
  assign m_valid  = w_match;
  assign m_wi     = w_match ? mem_rdata[GID_W +: WI_W] : '0;
  assign m_gid    = w_match ? mem_rdata[GID_W-1:0]     : '0;
  assign rd_done  = (r_state == DRAIN);
  assign rd_found = rd_done && (r_found || w_match);

  always_comb begin
    w_next    = r_state;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (!clr) begin
          if (wr_valid && (!rd_valid || r_last_rd)) begin
            wr_ready = 1'b1;
            w_next   = WRITE;
          end else if (rd_valid) begin
            rd_ready = 1'b1;
            w_next   = (r_occ[w_ibkt] == '0) ? DRAIN : READ;
          end
        end
      end
      WRITE: begin
        if (!w_wfull) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = {w_wbkt, r_occ[w_wbkt][SLOT_W-1:0]};
          mem_wdata = {w_wsig, r_wi, r_gid};
        end
        if (r_idx == IW'(S - 1)) w_next = IDLE;
      end
      READ: begin
        mem_en   = 1'b1;
        mem_addr = {w_rbkt, r_k[SLOT_W-1:0]};
        if ((r_k + OCC_ONE) == r_occ[w_rbkt]) w_next = DRAIN;
      end
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef LSH_DROP_CNT_EN
  logic [15:0] r_drop;
  assign drop_cnt = r_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop <= '0;
    end else if (r_state == IDLE && clr) begin
      r_drop <= '0;
    end else if (r_state == WRITE && w_wfull && r_drop != '1) begin
      r_drop <= r_drop + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_occ     <= '{default: '0};
      r_last_rd <= 1'b0;
      r_idx     <= '0;
      r_sig     <= '0;
      r_wi      <= '0;
      r_gid     <= '0;
      r_key     <= '0;
      r_k       <= '0;
      r_pend    <= 1'b0;
      r_found   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pend  <= (r_state == READ);
      case (r_state)
        IDLE: begin
          if (clr) r_occ <= '{default: '0};
          if (wr_ready) begin
            r_sig     <= wr_sig;
            r_wi      <= wr_wi;
            r_gid     <= wr_gid;
            r_idx     <= '0;
            r_last_rd <= 1'b0;
          end
          if (rd_ready) begin
            r_key     <= rd_key;
            r_k       <= '0;
            r_found   <= 1'b0;
            r_last_rd <= 1'b1;
          end
        end
        WRITE: begin
          r_idx <= r_idx + IW'(1);
          if (!w_wfull) r_occ[w_wbkt] <= r_occ[w_wbkt] + OCC_ONE;
        end
        READ: begin
          r_k     <= r_k + OCC_ONE;
          r_found <= r_found || w_match;
        end
        default: ;
      endcase
    end
  end

endmodule
